// File: rtl/crc_frame_ctrl_if.sv
// Stream-in / result-out handshake bundle for crc_frame_ctrl.
// slave = controller side, master = datapath side.
interface crc_frame_ctrl_if #(
  parameter int unsigned LEN_W = 16
) ();
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [7:0]       m_crc;
  logic [LEN_W-1:0] m_len;
  logic             m_ovf;
  logic             m_match;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_crc, m_len, m_ovf, m_match
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_crc, m_len, m_ovf, m_match
  );
endinterface

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a 2-bit/cycle CRC-8 engine: init at frame start, LSB dibit first,
// settle CRC_LAT cycles, then report CRC and length. Optional macro CRC_CHECK_EN adds m_match.
module crc_frame_ctrl #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CRC_LAT   = 1,
  parameter logic [7:0]  CHECK_RES = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  crc_frame_ctrl_if.slave bus,
  output logic            crc_init,
  output logic            crc_en,
  output logic [1:0]      crc_din,
  input  logic [7:0]      crc_val,
  output logic            busy
);
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0]       LAT_LAST = 3'(CRC_LAT - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       byte_reg;
  logic             last_reg;
  logic [1:0]       dibit_cnt;
  logic [2:0]       lat_cnt;
  logic [LEN_W-1:0] len_cnt;
  logic             ovf;
  logic             ready;
  logic             accept;
  logic             capture;
  logic             match_nxt;
  logic             res_valid;
  logic [7:0]       res_crc;
  logic [LEN_W-1:0] res_len;
  logic             res_ovf;
  logic             res_match;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus engine and handshake strobes; reset holds the engine in init
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    crc_init  = 1'b0;
    crc_en    = 1'b0;
    crc_din   = 2'b00;
    capture   = 1'b0;
    if (rst) begin
      state_nxt = ST_IDLE;
      crc_init  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          ready = 1'b1;
          if (bus.s_valid) begin
            crc_init  = 1'b1;
            state_nxt = ST_SHIFT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          crc_en  = 1'b1;
          crc_din = byte_reg[{dibit_cnt, 1'b0} +: 2];
          if (dibit_cnt != 2'd3) begin
            state_nxt = ST_SHIFT;
          end else if (last_reg) begin
            state_nxt = ST_DRAIN;
          end else begin
            ready     = 1'b1;
            state_nxt = bus.s_valid ? ST_SHIFT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          ready     = 1'b1;
          state_nxt = bus.s_valid ? ST_SHIFT : ST_WAIT;
        end
        ST_DRAIN: begin
          if (lat_cnt == LAT_LAST) begin
            capture   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_nxt = bus.m_ready ? ST_IDLE : ST_DONE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign accept      = bus.s_valid & ready;
  assign bus.s_ready = ready;
  assign busy        = ~rst & (state != ST_IDLE);

  // Byte/dibit/length/latency counters; first accept of a frame restarts length and overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_reg  <= 8'h00;
      last_reg  <= 1'b0;
      dibit_cnt <= 2'd0;
      lat_cnt   <= 3'd0;
      len_cnt   <= '0;
      ovf       <= 1'b0;
    end else begin
      if (accept) begin
        byte_reg  <= bus.s_data;
        last_reg  <= bus.s_last;
        dibit_cnt <= 2'd0;
        if (state == ST_IDLE) begin
          len_cnt <= LEN_ONE;
          ovf     <= 1'b0;
        end else if (&len_cnt) begin
          len_cnt <= len_cnt;
          ovf     <= 1'b1;
        end else begin
          len_cnt <= len_cnt + LEN_ONE;
          ovf     <= ovf;
        end
      end else begin
        dibit_cnt <= (state == ST_SHIFT) ? dibit_cnt + 2'd1 : dibit_cnt;
      end
      lat_cnt <= (state == ST_DRAIN) ? lat_cnt + 3'd1 : 3'd0;
    end
  end

`ifdef CRC_CHECK_EN
  assign match_nxt = (crc_val == CHECK_RES);
`else
  // Folds to constant 0; keeps the residue parameter referenced
  assign match_nxt = 1'b0 & (^CHECK_RES);
`endif

  // Result registers: captured on the last drain cycle, held until the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_crc   <= 8'h00;
      res_len   <= '0;
      res_ovf   <= 1'b0;
      res_match <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_crc   <= crc_val;
      res_len   <= len_cnt;
      res_ovf   <= ovf;
      res_match <= match_nxt;
    end else if ((state == ST_DONE) && bus.m_ready) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= res_valid;
    end
  end

  assign bus.m_valid = res_valid;
  assign bus.m_crc   = res_crc;
  assign bus.m_len   = res_len;
  assign bus.m_ovf   = res_ovf;
  assign bus.m_match = res_match;
endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl with a behavioural 2-bit/cycle CRC-8 engine (poly 0x07, init 0xFF).
module tb_crc_frame_ctrl;
  localparam int         TB_LEN_W = 2;
  localparam int         LEN_MAX  = (1 << TB_LEN_W) - 1;
  localparam logic [7:0] GOLD_A5  = 8'h81;

  typedef struct packed {
    logic [7:0]          crc;
    logic [TB_LEN_W-1:0] len;
    logic                ovf;
    logic                match;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       crc_init;
  logic       crc_en;
  logic [1:0] crc_din;
  logic [7:0] crc_val;
  logic [7:0] eng;
  logic       busy;
  logic       mv_prev = 1'b0;
  logic [7:0] last_crc = 8'h00;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mv_rises = 0;

  logic [7:0] tx[$];
  exp_t       sb[$];
  int         acc_cyc[$];
  int         init_log[$];
  int         en_cyc[$];
  logic [1:0] en_din[$];
  int         rdy_log[$];
  int         mv_log[$];

  crc_frame_ctrl_if #(.LEN_W(TB_LEN_W)) bus ();

  crc_frame_ctrl #(.LEN_W(TB_LEN_W), .CRC_LAT(1), .CHECK_RES(GOLD_A5)) dut (
    .clk(clk), .rst(rst), .bus(bus), .crc_init(crc_init), .crc_en(crc_en),
    .crc_din(crc_din), .crc_val(crc_val), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_of();
    logic [7:0] c;
    c = 8'hFF;
    foreach (tx[i]) for (int k = 0; k < 8; k++) c = crc_bit(c, tx[i][k]);
    return c;
  endfunction

  // External engine model: sync init, two bits per enabled cycle, din[0] first
  always @(posedge clk) begin
    if (crc_init) eng <= 8'hFF;
    else if (crc_en) eng <= crc_bit(crc_bit(eng, crc_din[0]), crc_din[1]);
  end
  assign crc_val = eng;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_exp();
    exp_t e;
    e.crc = crc_of();
    e.len = (tx.size() > LEN_MAX) ? TB_LEN_W'(LEN_MAX) : TB_LEN_W'(tx.size());
    e.ovf = (tx.size() > LEN_MAX);
`ifdef CRC_CHECK_EN
    e.match = (e.crc == GOLD_A5);
`else
    e.match = 1'b0;
`endif
    sb.push_back(e);
  endfunction

  // Monitor: logs per-cycle activity and pops the scoreboard on each result handshake
  always @(negedge clk) begin
    exp_t e;
    #2;
    check("init_en_excl", 32'(crc_init & crc_en), 32'd0);
    if (crc_init && !rst) init_log.push_back(cyc);
    if (crc_en) begin
      en_cyc.push_back(cyc);
      en_din.push_back(crc_din);
    end
    if (bus.s_ready) rdy_log.push_back(cyc);
    if (bus.m_valid && !mv_prev) begin
      mv_rises++;
      mv_log.push_back(cyc);
    end
    mv_prev = bus.m_valid;
    if (bus.m_valid && bus.m_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("m_crc", 32'(bus.m_crc), 32'(e.crc));
        check("m_len", 32'(bus.m_len), 32'(e.len));
        check("m_ovf", 32'(bus.m_ovf), 32'(e.ovf));
        check("m_match", 32'(bus.m_match), 32'(e.match));
        last_crc = bus.m_crc;
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic l);
    int wd;
    bit done;
    wd = 0;
    done = 1'b0;
    while (!done && wd < 100) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      bus.s_last  = l;
      #1;
      wd++;
      if (bus.s_ready) begin
        done = 1'b1;
        acc_cyc.push_back(cyc);
      end
    end
    check("accept_in_time", 32'(done), 32'd1);
  endtask

  task automatic send_frame(input int gap_at, input int gap_len);
    acc_cyc.delete(); init_log.delete(); en_cyc.delete();
    en_din.delete(); rdy_log.delete(); mv_log.delete();
    push_exp();
    for (int i = 0; i < tx.size(); i++) begin
      if (i == gap_at) repeat (gap_len) begin
        @(negedge clk);
        bus.s_valid = 1'b0;
      end
      drive_byte(tx[i], (i == tx.size() - 1));
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int wd;
    wd = 0;
    while ((sb.size() != 0 || bus.m_valid) && wd < 300) begin
      @(negedge clk);
      #3;
      wd++;
    end
    check("result_in_time", 32'(wd < 300), 32'd1);
  endtask

  task automatic analyze(input bit gapless);
    int n;
    int t0;
    int lat;
    logic [7:0] sh;
    n = tx.size();
    t0 = acc_cyc[0];
    check("init_count", init_log.size(), 32'd1);
    if (init_log.size() > 0) check("init_cyc", init_log[0] - t0, 32'd0);
    check("en_count", en_cyc.size(), 4 * n);
    for (int i = 0; i < en_din.size() && i < 4 * n; i++) begin
      sh = tx[i / 4] >> (2 * (i % 4));
      check("crc_din", 32'(en_din[i]), 32'(sh[1:0]));
      if (gapless) check("en_cyc", en_cyc[i] - t0, i + 1);
    end
    lat = -1;
    if (mv_log.size() > 0) lat = mv_log[0] - t0;
    if (gapless) check("mvalid_lat", lat, 4 * n + 2);
    else check("mvalid_lat_gap", lat, 4 * n + 2 + 5);
  endtask

  task automatic check_reset();
    check("rst_crc_init", 32'(crc_init), 32'd1);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_crc_en", 32'(crc_en), 32'd0);
    check("rst_crc_din", 32'(crc_din), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_crc", 32'(bus.m_crc), 32'd0);
    check("rst_m_len", 32'(bus.m_len), 32'd0);
    check("rst_m_ovf", 32'(bus.m_ovf), 32'd0);
    check("rst_m_match", 32'(bus.m_match), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int wd;
    int rises0;
    logic [7:0] hold_crc;
    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_s_ready", 32'(bus.s_ready), 32'd1);
    check("idle_crc_init", 32'(crc_init), 32'd0);

    tx = '{8'hA5};
    send_frame(-1, 0);
    wait_idle();
    analyze(1'b1);
    check("a5_golden", 32'(last_crc), 32'(GOLD_A5));

    tx = '{8'h01, 8'h02, 8'h03};
    send_frame(-1, 0);
    wait_idle();
    analyze(1'b1);
    n = 0;
    foreach (rdy_log[i]) begin
      if (rdy_log[i] <= acc_cyc[0] + 12) begin
        check("rdy_cyc", rdy_log[i] - acc_cyc[0], 4 * n);
        n++;
      end
    end
    check("rdy_count", n, 32'd3);

    send_frame(1, 8);
    wait_idle();
    analyze(1'b0);
    check("gap_accept", acc_cyc[1] - acc_cyc[0], 32'd9);
    if (en_cyc.size() > 4) check("gap_en_idle", en_cyc[4] - en_cyc[3], 32'd6);

    tx = '{8'h3C};
    hold_crc = crc_of();
    bus.m_ready = 1'b0;
    send_frame(-1, 0);
    wd = 0;
    while (!bus.m_valid && wd < 50) begin
      @(negedge clk);
      #1;
      wd++;
    end
    check("hold_reached", 32'(bus.m_valid), 32'd1);
    tx = '{8'h5A};
    push_exp();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h5A;
      bus.s_last  = 1'b1;
      #1;
      check("hold_m_valid", 32'(bus.m_valid), 32'd1);
      check("hold_m_crc", 32'(bus.m_crc), 32'(hold_crc));
      check("hold_s_ready", 32'(bus.s_ready), 32'd0);
    end
    check("hold_busy", 32'(busy), 32'd1);
    @(negedge clk);
    bus.m_ready = 1'b1;
    #1;
    check("hs_s_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    #1;
    check("post_hs_m_valid", 32'(bus.m_valid), 32'd0);
    check("post_hs_accept", 32'(bus.s_ready & bus.s_valid), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    wait_idle();

    tx = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    send_frame(-1, 0);
    wait_idle();
    tx = '{8'h11, 8'h22};
    send_frame(-1, 0);
    wait_idle();

    acc_cyc.delete();
    drive_byte(8'hA5, 1'b0);
    drive_byte(8'hB6, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    rises0 = mv_rises;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_crc_init", 32'(crc_init), 32'd1);
    check("midrst_crc_en", 32'(crc_en), 32'd0);
    @(negedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_result", mv_rises - rises0, 32'd0);
    tx = '{8'hA5};
    send_frame(-1, 0);
    wait_idle();
    analyze(1'b1);
    check("a5_rerun", 32'(last_crc), 32'(GOLD_A5));
    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
